// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store between EX/MEM and a word-only data memory.
// Sub-word stores use read-modify-write; misaligned or illegal-size requests answer with resp_err.
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [1:0] {IDLE, RD, WR, ERR} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              we_q, we_d, uns_q, uns_d;
    logic [31:0]       wdata_q, wdata_d, mem_wdata_q, mem_wdata_d, resp_rdata_q, resp_rdata_d;
    logic              resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
    logic              misaligned;
    logic [4:0]        sh;
    logic [31:0]       lane_mask, merged, rd_shift, load_data;

    assign misaligned = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0])
                     || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    // Lane offset in bits; halfwords are aligned so addr[1:0]*8 also selects the half lane.
    assign sh        = {addr_q[1:0], 3'b000};
    assign lane_mask = (size_q == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << sh;
    assign merged    = (mem_rdata & ~lane_mask) | ((wdata_q << sh) & lane_mask);
    assign rd_shift  = mem_rdata >> sh;
    assign load_data = size_q == 2'b00 ? {{24{~uns_q & rd_shift[7]}}, rd_shift[7:0]}
                     : size_q == 2'b01 ? {{16{~uns_q & rd_shift[15]}}, rd_shift[15:0]}
                     : mem_rdata;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        we_d         = we_q;
        uns_d        = uns_q;
        wdata_d      = wdata_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
        case (state_q)
            IDLE: if (req_valid) begin
                addr_d  = req_addr;
                size_d  = req_size;
                we_d    = req_we;
                uns_d   = req_unsigned;
                wdata_d = req_wdata;
                state_d = misaligned ? ERR : (req_we && req_size == 2'b10) ? WR : RD;
                if (!misaligned && req_we && req_size == 2'b10) mem_wdata_d = req_wdata;
            end
            RD: begin
                state_d = we_q ? WR : IDLE;
                if (we_q) mem_wdata_d = merged;
                resp_valid_d = ~we_q;
                resp_rdata_d = we_q ? 32'h0 : load_data;
            end
            WR: begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
            end
            ERR: begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            size_q       <= 2'b00;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            wdata_q      <= 32'h0;
            mem_wdata_q  <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            we_q         <= we_d;
            uns_q        <= uns_d;
            wdata_q      <= wdata_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready  = state_q == IDLE;
    assign mem_read   = state_q == RD;
    assign mem_write  = state_q == WR;
    assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table, reset/back-to-back sequences and random
// traffic checked against a byte-addressed reference memory.
module tb_load_store_unit;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        req_ready, resp_valid, resp_err, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] mem [64] = '{default: 32'h0};
    logic [7:0]  ref_b [256] = '{default: 8'h0};
    int checks = 0, failures = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;
    vec_t vecs[$];

    logic [31:0] bb_addr [3] = '{32'h10, 32'h22, 32'h11};
    logic [1:0]  bb_size [3] = '{2'b10, 2'b01, 2'b00};
    logic        bb_uns  [3] = '{1'b0, 1'b0, 1'b1};

    load_store_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
        .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
        if (mem_read) mem_rdata <= mem[mem_addr[7:2]];
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic ref_bad(input logic [1:0] size, input logic [31:0] addr);
        return size == 2'b11 || (addr % (32'd1 << size)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size,
                                             input logic uns);
        int n = 1 << size;
        logic [31:0] v = 32'h0;
        for (int i = 0; i < n; i++) v |= 32'(ref_b[int'(addr[7:0]) + i]) << (8 * i);
        if (!uns && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] d);
        for (int i = 0; i < (1 << size); i++) ref_b[int'(addr[7:0]) + i] = d[8*i +: 8];
    endtask

    // Called #1 after a rising edge with the unit idle; returns #1 after the response edge.
    task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic err, output int lat,
                        output int nrd, output int nwr);
        chk("ready_before_req", req_ready, 1'b1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; nrd = 0; nwr = 0;
        while (!resp_valid && lat < 8) begin
            nrd += int'(mem_read);
            nwr += int'(mem_write);
            if (mem_read || mem_write) chk("mem_addr", mem_addr, addr & ~32'd3);
            @(posedge clk); #1;
            lat++;
        end
        rd = resp_rdata;
        err = resp_err;
    endtask

    task automatic run_check(input string tag, input logic we, input logic [1:0] size,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        logic [31:0] rd;
        logic err;
        int lat, nrd, nwr;
        xact(we, size, uns, addr, wdata, rd, err, lat, nrd, nwr);
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_nread"}, nrd, (!exp_err && (!we || size != 2'b10)) ? 1 : 0);
        chk({tag, "_nwrite"}, nwr, (!exp_err && we) ? 1 : 0);
        if (we && !exp_err) ref_store(addr, size, wdata);
    endtask

    initial begin
        logic [31:0] a, wd;
        logic [1:0] sz;
        logic we, un, bad;
        int k, nresp, nw;

        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0, 1});
        vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF80, 32'h0, 1'b0, 2});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h11228044, 1'b0, 1});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'hFFFFFF80, 1'b0, 1});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h00000080, 1'b0, 1});
        vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h22, 32'h1234A55A, 32'h0, 1'b0, 2});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hA55A0000, 1'b0, 1});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'hFFFFA55A, 1'b0, 1});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'h0000A55A, 1'b0, 1});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 32'hFFFFFFA5, 1'b0, 1});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1});
        vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h05, 32'hBEEF, 32'h0, 1'b1, 1});
        vecs.push_back('{1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 32'h0, 1'b1, 1});

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", resp_err, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i])
            run_check($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr,
                      vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat);
        chk("word10_contents", mem[4], 32'h11228044);
        chk("word20_contents", mem[8], 32'hA55A0000);
        chk("word04_untouched", mem[1], 32'h0);

        run_check("preload08", 1'b1, 2'b10, 1'b0, 32'h08, 32'hCAFEF00D, 32'h0, 1'b0, 1);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h08; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort_in_rd", mem_read, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_req_ready", req_ready, 1'b1);
        chk("abort_mem_read", mem_read, 1'b0);
        chk("abort_mem_write", mem_write, 1'b0);
        chk("abort_mem_addr", mem_addr, 32'h0);
        chk("abort_mem_wdata", mem_wdata, 32'h0);
        chk("abort_resp_valid", resp_valid, 1'b0);
        nw = 0;
        repeat (3) begin
            @(negedge clk);
            nw += int'(mem_write);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_no_write", nw, 0);
        chk("abort_word08", mem[2], 32'hCAFEF00D);

        k = 0; nresp = 0;
        req_valid = 1'b1; req_we = 1'b0;
        req_addr = bb_addr[0]; req_size = bb_size[0]; req_unsigned = bb_uns[0];
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (resp_valid) begin
                nresp++;
                if (k < 3) chk($sformatf("b2b_rdata%0d", k), resp_rdata,
                               ref_load(bb_addr[k], bb_size[k], bb_uns[k]));
                k++;
                if (k < 3) begin
                    req_addr = bb_addr[k]; req_size = bb_size[k]; req_unsigned = bb_uns[k];
                end else req_valid = 1'b0;
            end
        end
        chk("b2b_resp_count", nresp, 3);

        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            un = 1'($urandom_range(0, 1));
            a = $urandom;
            if ($urandom_range(0, 3) != 0 && sz != 2'b11) a &= ~((32'd1 << sz) - 1);
            wd = $urandom;
            bad = ref_bad(sz, a);
            run_check($sformatf("rnd%0d", i), we, sz, un, a, wd,
                      (we || bad) ? 32'h0 : ref_load(a, sz, un), bad,
                      (!bad && we && sz != 2'b10) ? 2 : 1);
        end
        for (int w = 0; w < 64; w++)
            chk($sformatf("final_word%0d", w), mem[w], ref_load(32'(w * 4), 2'b10, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the EX/MEM pipeline register and the word-only data memory. It accepts one load or store request at a time and handles byte, halfword and word sizes. Sub-word stores are done as read-modify-write on the 32-bit memory. Load results are sign- or zero-extended, and misaligned accesses are flagged instead of reaching memory. The pipeline stalls while `req_ready` is low.

## Interface
- `ADDR_W`, 32: address width; `mem_addr` is always word-aligned.
- `clk` in 1: the single clock. The unit updates on the rising edge; the data memory samples on the falling edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present. A request is accepted on a rising edge when `req_valid & req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` in 1: load zero-extends when 1, sign-extends when 0. Ignored for stores.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `req_ready` out 1: high only in IDLE.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data. 0 for stores and errors.
- `resp_err` out 1: misaligned or illegal size. Valid with `resp_valid`.
- `mem_addr` out ADDR_W: `{addr[ADDR_W-1:2],2'b00}` of the captured request.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `mem_wdata` out 32: full word to write.
- `mem_rdata` in 32: memory read data. Valid after the falling edge of a `mem_read` cycle.

## Operation
- Four states: IDLE, RD, WR, ERR.
- On acceptance, the unit registers addr, size, we, unsigned and wdata.
- **Alignment:** a request is misaligned when half has `addr[0]=1`, word has `addr[1:0]≠0`, or size=11. Misaligned goes to ERR.
- **IDLE transitions** (misaligned excluded):
  - load goes to RD;
  - word store goes to WR, with `mem_wdata = wdata`;
  - byte or half store goes to RD (read phase of the read-modify-write).
- **RD:**
  - If the request is a load: on the next edge, extract and extend the load data, pulse `resp_valid`, and return to IDLE.
  - If the request is a store: merge the write data into `mem_rdata` and register the result into `mem_wdata`, then go to WR.
- **WR:** on the next edge, pulse `resp_valid` and return to IDLE.
- **ERR:** on the next edge, pulse `resp_valid` with `resp_err=1` and return to IDLE. No memory strobe is asserted.
- **Byte lanes** (little-endian):
  - byte `k = addr[1:0]` occupies bits [8k+7:8k];
  - half at `addr[1]=0` occupies [15:0], at `addr[1]=1` it occupies [31:16].
- **Merge:** only the addressed lane(s) take `wdata`; all other bits keep `mem_rdata`.
- **Extension:** bit 7 (byte) or bit 15 (half) is replicated when signed; zeros are used when unsigned. Word loads pass through unchanged.
- **Strobe decode:** `mem_read = (state==RD)` and `mem_write = (state==WR)`, decoded from state. They are never both high.
- `req_valid` while not ready is ignored; the request must be held by the pipeline.
- **Reset:**
  - Reset asserted at any time forces IDLE immediately. All registered outputs go to 0, and `mem_read`/`mem_write` drop asynchronously.
  - A read-modify-write aborted in RD leaves memory unmodified.

## Timing
- **Reset values:** `req_ready=1`, `resp_valid=0`, `resp_rdata=0`, `resp_err=0`, `mem_addr=0`, `mem_read=0`, `mem_write=0`, `mem_wdata=0`.
- Let acceptance be rising edge E0:
  - load: `resp_valid` is high from E1 to E2;
  - word store: memory is written at the falling edge between E0 and E1, and `resp_valid` is high from E1 to E2;
  - byte or half store: memory is read in E0–E1, written in E1–E2, and `resp_valid` is high from E2 to E3;
  - misaligned: `resp_valid` and `resp_err` are high from E1 to E2.
- `req_ready` is high during the `resp_valid` cycle, so back-to-back requests are accepted at the edge that ends the response cycle.
- A load immediately following a store to the same word sees the stored data, because the earlier write negedge has already completed.

## Test plan
- **Word store then word load:** store `0xDEADBEEF` to 0x10, then load word from 0x10. Required: `resp_rdata=0xDEADBEEF`, response 1 cycle after each acceptance, `resp_err=0`.
- **Byte stores:** store byte `0x80` to 0x11 into a word holding `0x11223344`. Required: word becomes `0x11228044`. A signed byte load from 0x11 returns `0xFFFFFF80`; an unsigned one returns `0x00000080`.
- **Half store:** store half `0xA55A` to 0x22 into `0x00000000`. Required: word becomes `0xA55A0000`. A signed half load returns `0xFFFFA55A`. The store response arrives 2 cycles after acceptance, with exactly one `mem_read` cycle and one `mem_write` cycle.
- **Misaligned accesses:** word load at 0x13 and half store at 0x05. Required: `resp_err=1`, `resp_rdata=0`, `mem_read` and `mem_write` never asserted, memory unchanged.
- **Reset mid read-modify-write:** assert `rst_n` low during the RD cycle of a byte store to 0x08. Required: outputs are 0 immediately, `req_ready=1`, no `mem_write` occurs, and word 0x08 is unchanged.
- **Back-to-back:** keep `req_valid` high for 3 consecutive loads. Required: each response precedes the next acceptance, with no dropped or duplicated `resp_valid`.
